ibex_ipm_unit: RTL

- Multi-cycle EX-stage execution unit for OPCODE_IPM instructions. Operates on inner-product-masked GF(2^8) values.
- Takes ipm_op_e operations and register operands from ID/EX. Returns a 32-bit result to the EX result mux using the same enable/valid handshake as the multiplier/divider.
- Each 32-bit operand packs 4 byte shares: share i at bits [8i+7:8i].
- Encoding: x = s0 ^ L1*s1 ^ L2*s2 ^ L3*s3 over GF(2^8) with polynomial 0x11B.

---
 rtl/ibex_ipm_unit_pkg.sv | 71 +++++++
 rtl/ibex_ipm_unit_gf_mul.sv | 17 +
 rtl/ibex_ipm_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ibex_ipm_unit_pkg.sv
// ibex_ipm_unit_pkg
// Shared types, constants and GF(2^8) helpers for the inner-product-masking
// (IPM) execution unit. The helper functions are used at elaboration time to
// build the constant tables (c_ij = Li*Lj, Li^2 ^ Li) from the public vector.
package ibex_ipm_unit_pkg;

    localparam int         IPM_N_SHARES = 4;
    localparam int         IPM_SHARE_W  = 8;
    localparam logic [8:0] IPM_GF_POLY  = 9'h11B;

    typedef enum logic [2:0] {
        IPM_MASK   = 3'd0,
        IPM_UNMASK = 3'd1,
        IPM_HOMOG  = 3'd2,
        IPM_SQUARE = 3'd3,
        IPM_MUL    = 3'd4
    } ipm_op_e;

    typedef enum logic [1:0] {
        IPM_IDLE = 2'd0,
        IPM_SQR  = 2'd1,
        IPM_STEP = 2'd2,
        IPM_DONE = 2'd3
    } ipm_state_e;

    typedef logic [IPM_N_SHARES-1:0][IPM_SHARE_W-1:0]              ipm_shares_t;
    typedef logic [IPM_N_SHARES*IPM_N_SHARES-1:0][IPM_SHARE_W-1:0] ipm_ctab_t;

    // Shift-and-add multiply, reducing by the AES polynomial as we go.
    function automatic logic [7:0] ipm_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? IPM_GF_POLY[7:0] : 8'h00);
        end
        return p;
    endfunction

    // Full public vector with L0 = 1 in slot 0.
    function automatic ipm_shares_t ipm_l_vec(input logic [23:0] l);
        return {l, 8'h01};
    endfunction

    // Li^2 ^ Li: re-encodes a share from the Li^2 basis into the Li basis.
    function automatic ipm_shares_t ipm_h_vec(input logic [23:0] l);
        ipm_shares_t lv;
        ipm_shares_t h;
        lv = ipm_l_vec(l);
        for (int i = 0; i < IPM_N_SHARES; i++) begin
            h[i] = ipm_gf_mul(lv[i], lv[i]) ^ lv[i];
        end
        return h;
    endfunction

    // c_ij = Li*Lj, flattened as entry 4*i+j.
    function automatic ipm_ctab_t ipm_c_tab(input logic [23:0] l);
        ipm_shares_t lv;
        ipm_ctab_t   c;
        lv = ipm_l_vec(l);
        for (int i = 0; i < IPM_N_SHARES; i++) begin
            for (int j = 0; j < IPM_N_SHARES; j++) begin
                c[i*IPM_N_SHARES+j] = ipm_gf_mul(lv[i], lv[j]);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ibex_ipm_unit_gf_mul.sv
// ibex_ipm_gf_mul
// Combinational 8x8 GF(2^8) multiplier, reduction mod 0x11B.
// Ports:
//   a_i  [7:0]  multiplicand
//   b_i  [7:0]  multiplier
//   p_o  [7:0]  product a_i*b_i
module ibex_ipm_gf_mul
    import ibex_ipm_unit_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = ipm_gf_mul(a_i, b_i);

endmodule

// File: rtl/ibex_ipm_unit.sv
// ibex_ipm_unit
// Multi-cycle EX-stage unit for inner-product-masked GF(2^8) operations.
// Each 32-bit operand holds four byte shares; x = s0 ^ L1*s1 ^ L2*s2 ^ L3*s3.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   ipm_en_i           request, held until valid_o; dropping it aborts
//   operator_i         ipm_op_e operation
//   op_a_i, op_b_i     operands (shares / secret byte / mask randoms)
//   rnd_i              fresh randoms for MUL, latched at start
//   result_o           result, meaningful while valid_o
//   valid_o            one-cycle completion pulse
//   busy_o             high in any non-IDLE state
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for ipm_en_i; operands latched on the start edge
// SQR      | SQUARE only: square all shares in place
// STEP     | one acc ^= k*(x*y) per cycle, counter runs down to 0
// DONE     | valid_o pulse, back to IDLE
module ibex_ipm_unit
    import ibex_ipm_unit_pkg::*;
#(
    parameter logic [23:0] IpmL = 24'h040302
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ipm_en_i,
    input  ipm_op_e     operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [23:0] rnd_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o
);

    localparam ipm_shares_t LVec = ipm_l_vec(IpmL);
    localparam ipm_shares_t HVec = ipm_h_vec(IpmL);
    localparam ipm_ctab_t   CTab = ipm_c_tab(IpmL);

    // Counter load value: number of STEP cycles minus one. Undefined
    // operators spend two STEP cycles so their latency is 2.
    function automatic logic [4:0] last_step(input ipm_op_e op);
        case (op)
            IPM_MASK, IPM_UNMASK, IPM_HOMOG, IPM_SQUARE: last_step = 5'd2;
            IPM_MUL:                                     last_step = 5'd18;
            default:                                     last_step = 5'd1;
        endcase
    endfunction

    ipm_state_e  state_q, state_d;
    ipm_op_e     op_q, op_d;
    ipm_shares_t a_q, a_d, b_q, b_d;
    logic [23:0] rnd_q, rnd_d;
    logic [7:0]  acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [4:0]  step_idx;
    logic [3:0]  prod_idx;
    logic [1:0]  sh_idx;
    logic [7:0]  mul_x, mul_y, scale_k, prod, term, acc_step;

    // Operand selection for the current step. The MUL sequence adds the
    // L-weighted randoms first so the accumulator is masked before any
    // share product is folded in.
    always_comb begin
        step_idx = last_step(op_q) - cnt_q;
        prod_idx = 4'(step_idx - 5'd3);
        sh_idx   = step_idx[1:0] + 2'd1;
        mul_x    = '0;
        mul_y    = 8'h01;
        scale_k  = '0;
        case (op_q)
            IPM_MASK: begin
                mul_x   = b_q[step_idx[1:0]];
                scale_k = LVec[sh_idx];
            end
            IPM_UNMASK: begin
                mul_x   = a_q[sh_idx];
                scale_k = LVec[sh_idx];
            end
            IPM_HOMOG, IPM_SQUARE: begin
                mul_x   = a_q[sh_idx];
                scale_k = HVec[sh_idx];
            end
            IPM_MUL: begin
                if (step_idx < 5'd3) begin
                    mul_x   = rnd_q[{step_idx[1:0], 3'b000} +: 8];
                    scale_k = LVec[sh_idx];
                end else begin
                    mul_x   = a_q[prod_idx[3:2]];
                    mul_y   = b_q[prod_idx[1:0]];
                    scale_k = CTab[prod_idx];
                end
            end
            default: ;
        endcase
    end

    ibex_ipm_gf_mul u_gf_prod (
        .a_i (mul_x),
        .b_i (mul_y),
        .p_o (prod)
    );

    ibex_ipm_gf_mul u_gf_scale (
        .a_i (prod),
        .b_i (scale_k),
        .p_o (term)
    );

    assign acc_step = acc_q ^ term;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rnd_d    = rnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IPM_IDLE: begin
                if (ipm_en_i) begin
                    op_d  = operator_i;
                    a_d   = op_a_i;
                    b_d   = op_b_i;
                    rnd_d = rnd_i;
                    cnt_d = last_step(operator_i);
                    case (operator_i)
                        IPM_MASK, IPM_UNMASK, IPM_HOMOG: acc_d = op_a_i[7:0];
                        default:                         acc_d = '0;
                    endcase
                    state_d = (operator_i == IPM_SQUARE) ? IPM_SQR : IPM_STEP;
                end
            end
            IPM_SQR: begin
                if (!ipm_en_i) begin
                    state_d = IPM_IDLE;
                end else begin
                    // Squaring is linear, so masked shares square independently.
                    for (int i = 0; i < IPM_N_SHARES; i++) begin
                        a_d[i] = ipm_gf_mul(a_q[i], a_q[i]);
                    end
                    acc_d   = ipm_gf_mul(a_q[0], a_q[0]);
                    state_d = IPM_STEP;
                end
            end
            IPM_STEP: begin
                if (!ipm_en_i) begin
                    state_d = IPM_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = IPM_DONE;
                        case (op_q)
                            IPM_MASK:              result_d = {b_q[2:0], acc_step};
                            IPM_UNMASK:            result_d = {24'h0, acc_step};
                            IPM_HOMOG, IPM_SQUARE: result_d = {a_q[3:1], acc_step};
                            IPM_MUL:               result_d = {rnd_q, acc_step};
                            default:               result_d = '0;
                        endcase
                    end
                end
            end
            IPM_DONE: state_d = IPM_IDLE;
            default:  state_d = IPM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IPM_IDLE;
            op_q     <= IPM_MASK;
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rnd_q    <= rnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign valid_o  = (state_q == IPM_DONE);
    assign busy_o   = (state_q != IPM_IDLE);

endmodule
